// File: rtl/rc5_encrypt_core.sv
// rtl/rc5_encrypt_core.sv - RC5-32 block encryption engine reading the expanded key table one word per half-step
module rc5_encrypt_core #(
  parameter int ROUNDS = 10,
  parameter int IDX_W  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             key_valid,
  input  logic [31:0]      pt_a,
  input  logic [31:0]      pt_b,
  output logic [IDX_W-1:0] skey_index,
  input  logic [31:0]      skey_data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      ct_a,
  output logic [31:0]      ct_b
);

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(2 * ROUNDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_KEY,
    FETCH,
    COMPUTE,
    FINISH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] k;
  logic [31:0]      a_reg;
  logic [31:0]      b_reg;
  logic [31:0]      a_next;
  logic [31:0]      b_next;

  // Upper half of the doubled word shifted left is the left rotation.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  always_comb begin
    a_next = a_reg;
    b_next = b_reg;
    if (k == '0) begin
      a_next = a_reg + skey_data;
    end else if (k == IDX_W'(1)) begin
      b_next = b_reg + skey_data;
    end else if (!k[0]) begin
      a_next = rotl32(a_reg ^ b_reg, b_reg[4:0]) + skey_data;
    end else begin
      b_next = rotl32(b_reg ^ a_reg, a_reg[4:0]) + skey_data;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    skey_index = '0;
    unique case (state)
      IDLE: begin
        if (start) state_next = WAIT_KEY;
      end
      WAIT_KEY: begin
        busy = 1'b1;
        if (key_valid) state_next = FETCH;
      end
      FETCH: begin
        busy       = 1'b1;
        skey_index = k;
        state_next = COMPUTE;
      end
      COMPUTE: begin
        busy       = 1'b1;
        skey_index = k;
        state_next = (k == LAST_K) ? FINISH : FETCH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ciphertext is latched on the edge into FINISH so it is valid alongside done.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      k     <= '0;
      a_reg <= '0;
      b_reg <= '0;
      ct_a  <= '0;
      ct_b  <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg <= pt_a;
            b_reg <= pt_b;
            k     <= '0;
          end
        end
        COMPUTE: begin
          a_reg <= a_next;
          b_reg <= b_next;
          if (k == LAST_K) begin
            ct_a <= a_next;
            ct_b <= b_next;
          end else begin
            k <= k + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_encrypt_core.sv
// tb/tb_rc5_encrypt_core.sv - scoreboard bench for rc5_encrypt_core at ROUNDS=1 and ROUNDS=10
module tb_rc5_encrypt_core;

  localparam int R10 = 10;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q10[$];
  exp_t e1;
  exp_t e10;

  // ROUNDS=1 instance
  logic        st1, kv1;
  logic [31:0] pa1, pb1, sd1, cta1, ctb1;
  logic [5:0]  si1;
  logic        busy1, done1;
  logic [31:0] key1 [0:63];

  // ROUNDS=10 instance
  logic        st10, kv10;
  logic [31:0] pa10, pb10, sd10, cta10, ctb10;
  logic [5:0]  si10;
  logic        busy10, done10;
  logic [31:0] key10 [0:63];

  rc5_encrypt_core #(.ROUNDS(1), .IDX_W(6)) dut1 (
    .clock(clock), .reset(reset), .start(st1), .key_valid(kv1),
    .pt_a(pa1), .pt_b(pb1), .skey_index(si1), .skey_data(sd1),
    .busy(busy1), .done(done1), .ct_a(cta1), .ct_b(ctb1)
  );

  rc5_encrypt_core #(.ROUNDS(R10), .IDX_W(6)) dut10 (
    .clock(clock), .reset(reset), .start(st10), .key_valid(kv10),
    .pt_a(pa10), .pt_b(pb10), .skey_index(si10), .skey_data(sd10),
    .busy(busy10), .done(done10), .ct_a(cta10), .ct_b(ctb10)
  );

  // Key tables answer one cycle after the index is presented.
  always @(posedge clock) begin
    sd1  <= key1[si1];
    sd10 <= key10[si10];
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [31:0] amt);
    int n;
    n = int'(amt & 32'd31);
    if (n == 0) return x;
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic void rc5_ref(input logic [31:0] ai, input logic [31:0] bi,
                                  output logic [31:0] ao, output logic [31:0] bo);
    logic [31:0] a, b;
    a = ai + key10[0];
    b = bi + key10[1];
    for (int i = 1; i <= R10; i++) begin
      a = rotl(a ^ b, b) + key10[2*i];
      b = rotl(b ^ a, a) + key10[2*i+1];
    end
    ao = a;
    bo = b;
  endfunction

  logic        log1_en = 1'b0;
  logic [5:0]  log1[$];

  always @(negedge clock) begin
    if (log1_en && busy1) log1.push_back(si1);
    if (done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL r1_unexpected_done: done=1 with nothing outstanding");
      end else begin
        e1 = q1.pop_front();
        check32("r1_ct_a", cta1, e1.a);
        check32("r1_ct_b", ctb1, e1.b);
        check32("r1_done_cycle", 32'(cyc), 32'(e1.cyc));
      end
    end
    if (done10) begin
      if (q10.size() == 0) begin
        checks++; errors++;
        $display("FAIL r10_unexpected_done: done=1 with nothing outstanding");
      end else begin
        e10 = q10.pop_front();
        check32("r10_ct_a", cta10, e10.a);
        check32("r10_ct_b", ctb10, e10.b);
        check32("r10_done_cycle", 32'(cyc), 32'(e10.cyc));
      end
    end
  end

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && (q1.size() != 0 || q10.size() != 0); i++) @(negedge clock);
    checks++;
    if (q1.size() != 0 || q10.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: outstanding=%0d expected 0", name, q1.size() + q10.size());
      q1.delete();
      q10.delete();
    end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic run1(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    pa1 = a; pb1 = b; st1 = 1'b1;
    e.a = ea; e.b = eb; e.cyc = cyc + 10;
    q1.push_back(e);
    @(negedge clock);
    st1 = 1'b0;
    drain(name, 40);
  endtask

  task automatic check_idle(input string name);
    check32({name, "_busy10"}, 32'(busy10), 32'd0);
    check32({name, "_done10"}, 32'(done10), 32'd0);
    check32({name, "_cta10"}, cta10, 32'd0);
    check32({name, "_ctb10"}, ctb10, 32'd0);
    check32({name, "_idx10"}, 32'(si10), 32'd0);
    check32({name, "_busy1"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ma, mb;
    logic [5:0]  exp_idx [0:8];

    reset = 1'b0; st1 = 1'b1; st10 = 1'b1; kv1 = 1'b1; kv10 = 1'b1;
    pa1 = 32'h1234_5678; pb1 = 32'h9abc_def0; pa10 = 32'hdead_beef; pb10 = 32'h0bad_f00d;
    for (int i = 0; i < 64; i++) begin
      key1[i]  = 32'h0;
      key10[i] = (32'h9e37_79b9 * 32'(i + 1)) ^ (32'hb7e1_5163 >> (i % 7));
    end

    // Reset held with start asserted
    repeat (3) begin
      @(negedge clock);
      check_idle("reset");
    end
    reset = 1'b1; st1 = 1'b0; st10 = 1'b0;
    @(negedge clock);
    check_idle("release");
    @(negedge clock);

    // Zero key, ROUNDS=1
    run1("zero_key", 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002);
    // Rotation uses low 5 bits only
    run1("rot_low5", 32'h0000_0001, 32'h0000_0004, 32'h0000_0050, 32'h0054_0000);

    // Pre-whitening with wrap, plus index sequence across WAIT/FETCH/COMPUTE
    key1[0] = 32'haaaa_aaaa; key1[1] = 32'h6666_6665;
    log1.delete();
    log1_en = 1'b1;
    run1("whiten_wrap", 32'h0, 32'h0, 32'h9999_99f9, 32'h39ff_ffff);
    log1_en = 1'b0;
    exp_idx = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd2, 6'd2, 6'd3, 6'd3};
    check32("idx_seq_len", 32'(log1.size()), 32'd9);
    for (int i = 0; i < 9 && i < log1.size(); i++)
      check32($sformatf("idx_seq_%0d", i), 32'(log1[i]), 32'(exp_idx[i]));

    // key_valid gating and start while busy, ROUNDS=10
    kv10 = 1'b0; pa10 = 32'h0123_4567; pb10 = 32'h89ab_cdef; st10 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      st10 = 1'b0;
      check32($sformatf("wait_key_busy_%0d", i), 32'(busy10), 32'd1);
      check32($sformatf("wait_key_idx_%0d", i), 32'(si10), 32'd0);
    end
    kv10 = 1'b1;
    rc5_ref(32'h0123_4567, 32'h89ab_cdef, ma, mb);
    e.a = ma; e.b = mb; e.cyc = cyc + 45;
    q10.push_back(e);
    repeat (10) @(negedge clock);
    pa10 = 32'hffff_ffff; pb10 = 32'h0; st10 = 1'b1;
    @(negedge clock);
    st10 = 1'b0;
    drain("kv_gate", 80);
    repeat (5) @(negedge clock);
    kv10 = 1'b0;
    @(negedge clock);
    kv10 = 1'b1;

    // Reset mid-operation, then a clean run
    pa10 = 32'hcafe_babe; pb10 = 32'h1357_9bdf; st10 = 1'b1;
    @(negedge clock);
    st10 = 1'b0;
    repeat (19) @(negedge clock);
    check32("midrun_busy", 32'(busy10), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check32("abort_busy", 32'(busy10), 32'd0);
    check32("abort_done", 32'(done10), 32'd0);
    check32("abort_idx", 32'(si10), 32'd0);
    reset = 1'b1;
    repeat (50) @(negedge clock);
    check32("abort_ct_a", cta10, 32'd0);
    pa10 = 32'h0000_0000; pb10 = 32'h8000_0001; st10 = 1'b1;
    rc5_ref(32'h0000_0000, 32'h8000_0001, ma, mb);
    e.a = ma; e.b = mb; e.cyc = cyc + 46;
    q10.push_back(e);
    @(negedge clock);
    st10 = 1'b0;
    drain("after_reset", 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
